// File: rtl/jb_dl_sat_pkg.sv
// Shared field layout, clear FSM states and helpers for the DL saturation error collector.
package jb_dl_sat_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned STICKY_LSB  = 0;
   localparam int unsigned LIVE_LSB    = 8;
   localparam int unsigned CNT_SAT_BIT = 15;
   localparam int unsigned CNT_LSB     = 16;
   localparam int unsigned CNT_W       = 16;
   localparam int unsigned MAX_ANT     = 8;
   localparam int unsigned PC_W        = 4;

   typedef enum logic [1:0] {
      IDLE,
      CLR,
      ACK,
      WAIT
   } clr_state_t;

   // Number of set bits in an antenna vector (zero-extended to MAX_ANT).
   function automatic logic [PC_W-1:0] popcount(input logic [MAX_ANT-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_ANT; i++) begin
         n = n + {{(PC_W-1){1'b0}}, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/jb_dl_sat_err_grp.sv
// One antenna group: sticky flags, saturating event count, windowed live flags and the
// req/ack clear sequencer that resets sticky/count without losing same-cycle events.
module jb_dl_sat_err_grp
   import jb_dl_sat_pkg::*;
#(
   parameter int unsigned GRP_ANT = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic [GRP_ANT-1:0] i_evt,
   input  logic               i_win_end,
   input  logic               i_clr_req,
   output logic               o_clr_ack,
   output logic [WORD_W-1:0]  o_status
);

   clr_state_t          r_state;
   logic                r_clr_ack;
   logic [GRP_ANT-1:0]  r_sticky;
   logic [GRP_ANT-1:0]  r_live;
   logic [GRP_ANT-1:0]  r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_cnt_sat;

   logic [GRP_ANT-1:0]  w_evt;
   logic [MAX_ANT-1:0]  w_evt_ext;
   logic [PC_W-1:0]     w_pc;
   logic [CNT_W:0]      w_sum;
   logic                w_ovf;

   // Gate events with enable and compute this cycle's contribution to the count.
   always_comb begin
      w_evt     = i_en ? i_evt : '0;
      w_evt_ext = '0;
      w_evt_ext[GRP_ANT-1:0] = w_evt;
      w_pc      = popcount(w_evt_ext);
      w_sum     = {1'b0, r_cnt} + (CNT_W+1)'(w_pc);
      w_ovf     = w_sum[CNT_W];
   end

   // Clear sequencer; ack is registered so it lands in the cycle after the clear takes effect.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_clr_ack <= 1'b0;
      end else begin
         r_clr_ack <= (r_state == CLR);
         case (r_state)
            IDLE:    if (i_clr_req) r_state <= CLR;
            CLR:     r_state <= ACK;
            ACK:     r_state <= WAIT;
            WAIT:    if (!i_clr_req) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Sticky/count update; in the CLR cycle the new period starts from this cycle's events.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sticky  <= '0;
         r_cnt     <= '0;
         r_cnt_sat <= 1'b0;
      end else if (r_state == CLR) begin
         r_sticky  <= w_evt;
         r_cnt     <= CNT_W'(w_pc);
         r_cnt_sat <= 1'b0;
      end else if (i_en) begin
         r_sticky  <= r_sticky | w_evt;
         r_cnt     <= w_ovf ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
         r_cnt_sat <= r_cnt_sat | w_ovf;
      end
   end

   // Window accumulator; an event in the window-end cycle seeds the next window.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_live <= '0;
         r_acc  <= '0;
      end else if (i_win_end) begin
         r_live <= r_acc;
         r_acc  <= w_evt;
      end else begin
         r_acc  <= r_acc | w_evt;
      end
   end

   // Pack the status word; unused bits stay 0.
   always_comb begin
      o_status = '0;
      o_status[STICKY_LSB +: GRP_ANT] = r_sticky;
      o_status[LIVE_LSB +: GRP_ANT]   = r_live;
      o_status[CNT_SAT_BIT]           = r_cnt_sat;
      o_status[CNT_LSB +: CNT_W]      = r_cnt;
   end

   assign o_clr_ack = r_clr_ack;

endmodule

// File: rtl/jb_dl_sat_err_collector.sv
// DL DFE saturation error collector: shared live-flag window timer plus one status
// word builder per antenna group.
module jb_dl_sat_err_collector
   import jb_dl_sat_pkg::*;
#(
   parameter int unsigned NUM_GRP = 2,
   parameter int unsigned GRP_ANT = 4,
   parameter int unsigned WIN_LEN = 61440
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_en,
   input  logic [NUM_GRP*GRP_ANT-1:0]       i_sat_evt,
   input  logic [NUM_GRP-1:0]               i_clr_req,
   output logic [NUM_GRP-1:0]               o_clr_ack,
   output logic [NUM_GRP-1:0][WORD_W-1:0]   o_sat_err_status,
   output logic                             o_win_tick
);

   localparam int unsigned WIN_W = $clog2(WIN_LEN);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

   logic [WIN_W-1:0] r_win_cnt;
   logic             r_win_tick;
   logic             w_win_end;
   logic [WIN_W-1:0] w_win_cnt_nxt;

   // Window end decode and next counter value.
   always_comb begin
      w_win_end     = (r_win_cnt == WIN_LAST);
      w_win_cnt_nxt = w_win_end ? '0 : r_win_cnt + WIN_W'(1);
   end

   // Free-running window counter (independent of enable); tick is high while the count sits at the end.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_win_cnt  <= '0;
         r_win_tick <= 1'b0;
      end else begin
         r_win_cnt  <= w_win_cnt_nxt;
         r_win_tick <= (w_win_cnt_nxt == WIN_LAST);
      end
   end

   assign o_win_tick = r_win_tick;

   for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
      jb_dl_sat_err_grp #(
         .GRP_ANT (GRP_ANT)
      ) u_grp (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_en      (i_en),
         .i_evt     (i_sat_evt[g*GRP_ANT +: GRP_ANT]),
         .i_win_end (w_win_end),
         .i_clr_req (i_clr_req[g]),
         .o_clr_ack (o_clr_ack[g]),
         .o_status  (o_sat_err_status[g])
      );
   end

endmodule

// File: tb/tb_jb_dl_sat_err_collector.sv
// Self-checking bench for jb_dl_sat_err_collector: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the status words.
module tb_jb_dl_sat_err_collector;

   localparam int NG = 2;
   localparam int GA = 4;
   localparam int WL = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic [NG*GA-1:0]    sat_evt;
   logic [NG-1:0]       clr_req;
   logic [NG-1:0]       clr_ack;
   logic [NG-1:0][31:0] status;
   logic                win_tick;

   always #5 clk = ~clk;

   jb_dl_sat_err_collector #(
      .NUM_GRP (NG),
      .GRP_ANT (GA),
      .WIN_LEN (WL)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_en             (en),
      .i_sat_evt        (sat_evt),
      .i_clr_req        (clr_req),
      .o_clr_ack        (clr_ack),
      .o_sat_err_status (status),
      .o_win_tick       (win_tick)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: plain integers per group, clear progress as a phase number.
   int       m_cnt    [NG];
   bit       m_sat    [NG];
   bit [3:0] m_sticky [NG];
   bit [3:0] m_live   [NG];
   bit [3:0] m_acc    [NG];
   int       m_phase  [NG];  // 0 none, 1 clearing, 2 acking, 3 waiting for req drop
   int       m_cyc;
   bit       m_tick;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%08h, want 0x%08h", tag, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] m_word(input int g);
      return (32'(m_cnt[g]) << 16) | (32'(m_sat[g]) << 15) | (32'(m_live[g]) << 8)
             | 32'(m_sticky[g]);
   endfunction

   function automatic void m_reset();
      for (int g = 0; g < NG; g++) begin
         m_cnt[g] = 0; m_sat[g] = 0; m_sticky[g] = '0;
         m_live[g] = '0; m_acc[g] = '0; m_phase[g] = 0;
      end
      m_cyc  = 0;
      m_tick = 0;
   endfunction

   // One clock edge worth of behaviour, using the inputs as presented to that edge.
   function automatic void m_edge();
      bit win_end;
      win_end = (m_cyc % WL) == WL - 1;
      for (int g = 0; g < NG; g++) begin
         bit [3:0] e;
         int n;
         e = en ? sat_evt[g*GA +: GA] : 4'h0;
         n = $countones(e);
         if (m_phase[g] == 1) begin
            m_sticky[g] = e; m_cnt[g] = n; m_sat[g] = 0;
         end else begin
            m_sticky[g] |= e;
            if (m_cnt[g] + n > 65535) begin
               m_cnt[g] = 65535; m_sat[g] = 1;
            end else begin
               m_cnt[g] += n;
            end
         end
         if (win_end) begin
            m_live[g] = m_acc[g]; m_acc[g] = e;
         end else begin
            m_acc[g] |= e;
         end
         case (m_phase[g])
            0: if (clr_req[g]) m_phase[g] = 1;
            1: m_phase[g] = 2;
            2: m_phase[g] = 3;
            default: if (!clr_req[g]) m_phase[g] = 0;
         endcase
      end
      m_cyc++;
      m_tick = (m_cyc % WL) == WL - 1;
   endfunction

   task automatic check_all();
      for (int g = 0; g < NG; g++) begin
         chk($sformatf("word%0d", g), status[g], m_word(g));
         chk($sformatf("ack%0d", g), {31'b0, clr_ack[g]}, {31'b0, m_phase[g] == 2});
      end
      chk("win_tick", {31'b0, win_tick}, {31'b0, m_tick});
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; sat_evt = '0; clr_req = '0;
      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all();

      // Single pulse on antenna 1: one-cycle latency, then live flag after the window end.
      repeat (5) tick();
      sat_evt = 8'h02;
      tick();
      sat_evt = '0;
      chk("evt_lat", status[0], 32'h0001_0002);
      repeat (40) tick();

      // Long saturation on group 0, then a clear.
      sat_evt = 8'h0F;
      repeat (20000) tick();
      chk("cnt_sat", {15'b0, status[0][31:15]}, 32'h0001_FFFF);
      chk("sticky_all", {28'b0, status[0][3:0]}, 32'h0000_000F);
      sat_evt = '0;
      clr_req[0] = 1'b1;
      repeat (3) tick();
      clr_req[0] = 1'b0;
      repeat (3) tick();
      chk("cleared_cnt", {16'b0, status[0][31:16]}, 32'h0);

      // Event on ant2 in the CLR cycle, request held for 10 cycles.
      clr_req[0] = 1'b1;
      tick();
      sat_evt = 8'h04;
      tick();
      sat_evt = '0;
      chk("clr_evt_word", {16'b0, status[0][31:16]}, 32'h1);
      repeat (10) tick();
      clr_req[0] = 1'b0;
      repeat (3) tick();

      // Enable low: words frozen, clear still served.
      en = 1'b0;
      sat_evt = 8'hFF;
      repeat (10) tick();
      clr_req[1] = 1'b1;
      repeat (10) tick();
      clr_req[1] = 1'b0;
      repeat (10) tick();
      en = 1'b1;
      sat_evt = 8'hA5;
      repeat (5) tick();
      sat_evt = '0;

      // Reset during CLR with request held.
      clr_req = 2'b11;
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_word0", status[0], 32'h0);
      chk("rst_word1", status[1], 32'h0);
      chk("rst_ack", {30'b0, clr_ack}, 32'h0);
      chk("rst_tick", {31'b0, win_tick}, 32'h0);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_ack", {30'b0, clr_ack}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) tick();
      clr_req = '0;
      repeat (3) tick();

      // Random traffic with random enable and clear requests.
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom % 8) != 0;
         sat_evt = 8'($urandom & $urandom);
         for (int g = 0; g < NG; g++) begin
            if (($urandom % 16) == 0) clr_req[g] = ~clr_req[g];
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
